// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants: load-size encodings, register zero, datapath defaults.
package mips_pkg;

   localparam logic [1:0] LD_B = 2'b00;
   localparam logic [1:0] LD_H = 2'b01;
   localparam logic [1:0] LD_W = 2'b10;

   localparam logic [4:0] REG_ZERO = 5'd0;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_ADDR_W = 5;

endpackage

// File: rtl/load_align.sv
// Little-endian load data alignment and sign/zero extension for byte, half and word loads.
module load_align
   import mips_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  offset,
   input  logic [1:0]  size,
   input  logic        is_unsigned,
   output logic [31:0] data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = rdata[7:0];
      case (offset)
         2'd0: byte_sel = rdata[7:0];
         2'd1: byte_sel = rdata[15:8];
         2'd2: byte_sel = rdata[23:16];
         2'd3: byte_sel = rdata[31:24];
         default: byte_sel = rdata[7:0];
      endcase
      // offset[0] is ignored for halfwords; misalignment is not trapped here
      half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
   end

   always_comb begin
      data = rdata;
      case (size)
         LD_B: data = is_unsigned ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
         LD_H: data = is_unsigned ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
         default: data = rdata;
      endcase
   end

endmodule

// File: rtl/wb_stage.sv
// MIPS writeback stage: registers one register-file write per cycle from the MEM stage
// or an auxiliary valid/ready source (main has priority), and counts retired instructions.
module wb_stage
   import mips_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              m_valid,
   input  logic              m_reg_write,
   input  logic [ADDR_W-1:0] m_dest,
   input  logic [DATA_W-1:0] m_alu,
   input  logic              m_load,
   input  logic [1:0]        m_ld_size,
   input  logic              m_ld_unsigned,
   input  logic [DATA_W-1:0] m_rdata,
   input  logic              x_valid,
   input  logic [ADDR_W-1:0] x_dest,
   input  logic [DATA_W-1:0] x_data,
   output logic              x_ready,
   output logic              reg_write,
   output logic [ADDR_W-1:0] write_addr,
   output logic [DATA_W-1:0] write_d,
   output logic [CNT_W-1:0]  retire_cnt
);

   logic              main_wr;
   logic              x_fire;
   logic [DATA_W-1:0] ld_data;
   logic [DATA_W-1:0] main_data;

   load_align u_load_align (
      .rdata       (m_rdata),
      .offset      (m_alu[1:0]),
      .size        (m_ld_size),
      .is_unsigned (m_ld_unsigned),
      .data        (ld_data)
   );

   assign main_wr   = m_valid & m_reg_write & (m_dest != ADDR_W'(REG_ZERO));
   // rst gates x_ready so no handshake can complete while the stage is held in reset
   assign x_ready   = rst & ~main_wr;
   assign x_fire    = x_valid & x_ready;
   assign main_data = m_load ? ld_data : m_alu;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         reg_write  <= 1'b0;
         write_addr <= '0;
         write_d    <= '0;
         retire_cnt <= '0;
      end else begin
         if (main_wr) begin
            reg_write  <= 1'b1;
            write_addr <= m_dest;
            write_d    <= main_data;
         end else if (x_fire) begin
            reg_write  <= (x_dest != ADDR_W'(REG_ZERO));
            write_addr <= x_dest;
            write_d    <= x_data;
         end else begin
            reg_write  <= 1'b0;
         end

         if (m_valid) begin
            retire_cnt <= retire_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: reset, load alignment, aux contention, $zero, counter wrap, async reset.
module tb_wb_stage;
   import mips_pkg::*;

   logic        clk;
   logic        rst;
   logic        m_valid;
   logic        m_reg_write;
   logic [4:0]  m_dest;
   logic [31:0] m_alu;
   logic        m_load;
   logic [1:0]  m_ld_size;
   logic        m_ld_unsigned;
   logic [31:0] m_rdata;
   logic        x_valid;
   logic [4:0]  x_dest;
   logic [31:0] x_data;
   logic        x_ready;
   logic        reg_write;
   logic [4:0]  write_addr;
   logic [31:0] write_d;
   logic [31:0] retire_cnt;

   logic        x_ready4;
   logic        reg_write4;
   logic [4:0]  write_addr4;
   logic [31:0] write_d4;
   logic [3:0]  retire_cnt4;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   wb_stage dut (
      .clk(clk), .rst(rst),
      .m_valid(m_valid), .m_reg_write(m_reg_write), .m_dest(m_dest), .m_alu(m_alu),
      .m_load(m_load), .m_ld_size(m_ld_size), .m_ld_unsigned(m_ld_unsigned), .m_rdata(m_rdata),
      .x_valid(x_valid), .x_dest(x_dest), .x_data(x_data), .x_ready(x_ready),
      .reg_write(reg_write), .write_addr(write_addr), .write_d(write_d), .retire_cnt(retire_cnt)
   );

   wb_stage #(.CNT_W(4)) dut4 (
      .clk(clk), .rst(rst),
      .m_valid(m_valid), .m_reg_write(m_reg_write), .m_dest(m_dest), .m_alu(m_alu),
      .m_load(m_load), .m_ld_size(m_ld_size), .m_ld_unsigned(m_ld_unsigned), .m_rdata(m_rdata),
      .x_valid(x_valid), .x_dest(x_dest), .x_data(x_data), .x_ready(x_ready4),
      .reg_write(reg_write4), .write_addr(write_addr4), .write_d(write_d4), .retire_cnt(retire_cnt4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic main_write(input logic [4:0] dest, input logic [31:0] alu);
      m_valid = 1'b1; m_reg_write = 1'b1; m_dest = dest; m_alu = alu; m_load = 1'b0;
   endtask

   task automatic do_load(input string tag, input logic [1:0] size, input logic uns,
                          input logic [1:0] off, input logic [31:0] exp);
      m_valid = 1'b1; m_reg_write = 1'b1; m_dest = 5'd5; m_load = 1'b1;
      m_ld_size = size; m_ld_unsigned = uns; m_alu = {30'h1000, off}; m_rdata = 32'h80FF7F01;
      step();
      chk({tag, "_we"}, {31'h0, reg_write}, 32'd1);
      chk(tag, write_d, exp);
   endtask

   initial begin
      // reset held with random inputs
      rst = 1'b0;
      m_valid = 1'b1; m_reg_write = 1'b1; m_dest = 5'd7;
      m_alu = $urandom; m_load = $urandom_range(0, 1); m_ld_size = 2'($urandom_range(0, 3));
      m_ld_unsigned = $urandom_range(0, 1); m_rdata = $urandom;
      x_valid = 1'b1; x_dest = 5'd2; x_data = $urandom;
      step(); step();
      chk("rst_we",   {31'h0, reg_write}, 32'd0);
      chk("rst_addr", {27'h0, write_addr}, 32'd0);
      chk("rst_d",    write_d, 32'd0);
      chk("rst_cnt",  retire_cnt, 32'd0);
      chk("rst_xrdy", {31'h0, x_ready}, 32'd0);

      rst = 1'b1;
      x_valid = 1'b0;
      main_write(5'd3, 32'h12345678);
      step();
      chk("first_we",   {31'h0, reg_write}, 32'd1);
      chk("first_addr", {27'h0, write_addr}, 32'd3);
      chk("first_d",    write_d, 32'h12345678);
      chk("first_cnt",  retire_cnt, 32'd1);

      do_load("lb3",  LD_B, 1'b0, 2'd3, 32'hFFFFFF80);
      do_load("lbu3", LD_B, 1'b1, 2'd3, 32'h00000080);
      do_load("lb1",  LD_B, 1'b0, 2'd1, 32'h0000007F);
      do_load("lh2",  LD_H, 1'b0, 2'd2, 32'hFFFF80FF);
      do_load("lhu0", LD_H, 1'b1, 2'd0, 32'h00007F01);
      do_load("lw",   LD_W, 1'b0, 2'd3, 32'h80FF7F01);
      chk("load_cnt", retire_cnt, 32'd7);

      // aux request starved by three back-to-back main writes
      x_valid = 1'b1; x_dest = 5'd9; x_data = 32'hDEAD0000;
      for (int unsigned i = 0; i < 3; i++) begin
         main_write(5'd4, 32'hA0 + i);
         #1;
         chk("cont_xrdy0", {31'h0, x_ready}, 32'd0);
         step();
         chk("cont_addr", {27'h0, write_addr}, 32'd4);
         chk("cont_d",    write_d, 32'hA0 + i);
      end
      m_valid = 1'b0; m_reg_write = 1'b0;
      #1;
      chk("cont_xrdy1", {31'h0, x_ready}, 32'd1);
      step();
      x_valid = 1'b0;
      chk("aux_we",   {31'h0, reg_write}, 32'd1);
      chk("aux_addr", {27'h0, write_addr}, 32'd9);
      chk("aux_d",    write_d, 32'hDEAD0000);
      step();
      chk("idle_we",   {31'h0, reg_write}, 32'd0);
      chk("idle_addr", {27'h0, write_addr}, 32'd9);
      chk("idle_d",    write_d, 32'hDEAD0000);
      chk("cont_cnt",  retire_cnt, 32'd10);

      // $zero destination and non-writing instruction
      main_write(5'd0, 32'h11111111);
      #1;
      chk("zero_xrdy", {31'h0, x_ready}, 32'd1);
      step();
      chk("zero_we",  {31'h0, reg_write}, 32'd0);
      chk("zero_cnt", retire_cnt, 32'd11);
      m_valid = 1'b1; m_reg_write = 1'b0; m_dest = 5'd6;
      #1;
      chk("nowr_xrdy", {31'h0, x_ready}, 32'd1);
      step();
      chk("nowr_we",  {31'h0, reg_write}, 32'd0);
      chk("nowr_cnt", retire_cnt, 32'd12);
      m_valid = 1'b0;
      x_valid = 1'b1; x_dest = 5'd0; x_data = 32'h55555555;
      #1;
      chk("auxz_xrdy", {31'h0, x_ready}, 32'd1);
      step();
      x_valid = 1'b0;
      chk("auxz_we",  {31'h0, reg_write}, 32'd0);
      chk("auxz_cnt", retire_cnt, 32'd12);

      // async reset between edges while a write is being presented
      main_write(5'd12, 32'hCAFEF00D);
      step();
      chk("pre_rst_we", {31'h0, reg_write}, 32'd1);
      main_write(5'd13, 32'hBEEF0001);
      #2;
      rst = 1'b0;
      #1;
      chk("arst_we",   {31'h0, reg_write}, 32'd0);
      chk("arst_d",    write_d, 32'd0);
      chk("arst_cnt",  retire_cnt, 32'd0);
      chk("arst_xrdy", {31'h0, x_ready}, 32'd0);
      step();
      chk("arst_edge_we", {31'h0, reg_write}, 32'd0);

      // counter wrap on the 4-bit instance
      rst = 1'b1;
      m_valid = 1'b1; m_reg_write = 1'b0;
      for (int unsigned i = 0; i < 17; i++) step();
      m_valid = 1'b0;
      chk("wrap_cnt4", {28'h0, retire_cnt4}, 32'd1);
      chk("wrap_cnt32", retire_cnt, 32'd17);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
